param_metronome: RTL and testbench

- Parametrised next-generation metronome for the keyboard board.
- Generates beat ticks from a phase accumulator, so the beat period averages out exactly for any CLK_HZ/BPM pair with no truncation drift.
- Drives an N-LED bounce sweep locked to the beat, and a speaker click whose pulse is longer on the bar's accented downbeat.
- Adjusts tempo from a preset load or debounced, edge-detected up/down keys; exports tempo as registered BCD digits for the seven-segment decoders.

---
 rtl/param_metronome.sv | 222 ++++++++++++++++++++++
 tb/tb_param_metronome.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_metronome.sv
// Phase-accumulator metronome: drift-free beat ticks, bar counting with an accented click,
// a beat-locked LED bounce sweep, debounced tempo keys and a registered BCD tempo readout.
module param_metronome #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned N_LEDS      = 8,
    parameter int unsigned BPM_MIN     = 40,
    parameter int unsigned BPM_MAX     = 240,
    parameter int unsigned BPM_DEFAULT = 120,
    parameter int unsigned CLICK_CYC   = 500000,
    parameter int unsigned ACCENT_CYC  = 1500000,
    parameter int unsigned DB_CYC      = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              bpm_load,
    input  logic [9:0]        bpm_in,
    input  logic              key_up_n,
    input  logic              key_dn_n,
    input  logic [2:0]        beats_per_bar,
    output logic [9:0]        bpm,
    output logic [3:0]        bcd100,
    output logic [3:0]        bcd10,
    output logic [3:0]        bcd1,
    output logic [N_LEDS-1:0] led,
    output logic              beat,
    output logic [2:0]        beat_idx,
    output logic              speaker
);

    localparam longint unsigned THR       = 64'(60) * 64'(CLK_HZ);
    localparam int unsigned     S         = 2 * (N_LEDS - 1);
    localparam int              ACC_W     = $clog2(THR + 64'(BPM_MAX)) + 1;
    localparam int              SACC_W    = $clog2(THR + 64'(BPM_MAX) * 64'(S)) + 1;
    localparam int              POS_W     = $clog2(S);
    localparam int unsigned     CLICK_MAX = (ACCENT_CYC > CLICK_CYC) ? ACCENT_CYC : CLICK_CYC;
    localparam int              CLICK_W   = (CLICK_MAX > 0) ? $clog2(CLICK_MAX + 1) : 1;
    localparam int unsigned     DB_LAST   = (DB_CYC > 1) ? DB_CYC - 1 : 0;
    localparam int              DB_W      = (DB_LAST > 0) ? $clog2(DB_LAST + 1) : 1;

    localparam logic [ACC_W-1:0]   THR_A     = ACC_W'(THR);
    localparam logic [SACC_W-1:0]  THR_S     = SACC_W'(THR);
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(S - 1);
    localparam logic [CLICK_W-1:0] LEN_ACC   = CLICK_W'(ACCENT_CYC);
    localparam logic [CLICK_W-1:0] LEN_CLICK = CLICK_W'(CLICK_CYC);

    // Double-dabble binary to three BCD digits; bpm never exceeds 999.
    function automatic logic [11:0] to_bcd(input logic [9:0] bin);
        logic [11:0] d;
        d = '0;
        for (int i = 9; i >= 0; i--) begin
            if (d[3:0]  >= 4'd5) d[3:0]  = d[3:0]  + 4'd3;
            if (d[7:4]  >= 4'd5) d[7:4]  = d[7:4]  + 4'd3;
            if (d[11:8] >= 4'd5) d[11:8] = d[11:8] + 4'd3;
            d = {d[10:0], bin[i]};
        end
        return d;
    endfunction

    // ---------------------------------------------------------------- keys
    // Index 0 is the up key, index 1 the down key; idle level is 1 (released).
    logic [1:0]           w_keys_raw;
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_db_level;
    logic [1:0]           r_db_prev;
    logic [1:0][DB_W-1:0] r_db_cnt;
    logic [1:0]           w_key_fall;

    assign w_keys_raw = {key_dn_n, key_up_n};

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_db_level <= 2'b11;
            r_db_prev  <= 2'b11;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= w_keys_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_db_level[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_W'(DB_LAST)) begin
                    r_db_level[k] <= r_sync2[k];
                    r_db_cnt[k]   <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_key_fall = r_db_prev & ~r_db_level;

    // --------------------------------------------------------------- tempo
    logic [9:0]  r_bpm;
    logic [9:0]  w_bpm_clamped;
    logic [11:0] r_bcd;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_bpm_clamped = bpm_in;
        if (bpm_in < 10'(BPM_MIN)) begin
            w_bpm_clamped = 10'(BPM_MIN);
        end else if (bpm_in > 10'(BPM_MAX)) begin
            w_bpm_clamped = 10'(BPM_MAX);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bpm <= 10'(BPM_DEFAULT);
        end else if (bpm_load) begin
            r_bpm <= w_bpm_clamped;
        end else if (w_key_fall == 2'b01) begin
            if (r_bpm < 10'(BPM_MAX)) r_bpm <= r_bpm + 10'd1;
        end else if (w_key_fall == 2'b10) begin
            if (r_bpm > 10'(BPM_MIN)) r_bpm <= r_bpm - 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bcd <= to_bcd(10'(BPM_DEFAULT));
        end else begin
            r_bcd <= to_bcd(r_bpm);
        end
    end

    // ------------------------------------------------- beat, bar, click, sweep
    logic                 r_run_q;
    logic                 r_beat;
    logic [ACC_W-1:0]     r_acc;
    logic [SACC_W-1:0]    r_sacc;
    logic [POS_W-1:0]     r_pos;
    logic [2:0]           r_idx;
    logic [CLICK_W-1:0]   r_click;

    logic [ACC_W-1:0]     w_acc_sum;
    logic                 w_acc_ovf;
    logic [SACC_W-1:0]    w_sweep_inc;
    logic [SACC_W-1:0]    w_sacc_sum;
    logic                 w_sacc_ovf;
    logic                 w_start;
    logic                 w_beat;
    logic [2:0]           w_bar_len;
    logic [3:0]           w_idx_inc;
    logic [2:0]           w_idx_next;

    assign w_acc_sum   = r_acc + ACC_W'(r_bpm);
    assign w_acc_ovf   = (w_acc_sum >= THR_A);
    assign w_sweep_inc = SACC_W'(r_bpm) * SACC_W'(S);
    assign w_sacc_sum  = r_sacc + w_sweep_inc;
    assign w_sacc_ovf  = (w_sacc_sum >= THR_S);
    assign w_start     = run & ~r_run_q;
    assign w_beat      = run & (w_start | w_acc_ovf);
    assign w_bar_len   = (beats_per_bar == 3'd0) ? 3'd1 : beats_per_bar;
    assign w_idx_inc   = {1'b0, r_idx} + 4'd1;
    // The start beat always opens a new bar.
    assign w_idx_next  = (w_start || (w_idx_inc >= {1'b0, w_bar_len})) ? 3'd0 : w_idx_inc[2:0];

    always_ff @(posedge clock) begin
        if (!reset || !run) begin
            r_run_q <= 1'b0;
            r_beat  <= 1'b0;
            r_acc   <= '0;
            r_sacc  <= '0;
            r_pos   <= '0;
            r_idx   <= '0;
            r_click <= '0;
        end else begin
            r_run_q <= 1'b1;
            r_beat  <= w_beat;

            if (w_start) begin
                r_acc <= '0;
            end else if (w_acc_ovf) begin
                r_acc <= w_acc_sum - THR_A;
            end else begin
                r_acc <= w_acc_sum;
            end

            // A beat re-aligns the sweep and (re)starts the click.
            if (w_beat) begin
                r_idx   <= w_idx_next;
                r_click <= (w_idx_next == 3'd0) ? LEN_ACC : LEN_CLICK;
                r_pos   <= '0;
                r_sacc  <= '0;
            end else begin
                if (r_click != '0) r_click <= r_click - 1'b1;
                if (w_sacc_ovf) begin
                    r_sacc <= w_sacc_sum - THR_S;
                    r_pos  <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
                end else begin
                    r_sacc <= w_sacc_sum;
                end
            end
        end
    end

    // Positions 0..N-1 walk up the LEDs, N..S-1 walk back down towards LED 1.
    logic [31:0] w_led_sel;

    always_comb begin
        w_led_sel = 32'(r_pos);
        if (w_led_sel >= N_LEDS) w_led_sel = S - w_led_sel;
    end

    assign led      = N_LEDS'(1) << w_led_sel;
    assign bpm      = r_bpm;
    assign bcd100   = r_bcd[11:8];
    assign bcd10    = r_bcd[7:4];
    assign bcd1     = r_bcd[3:0];
    assign beat     = r_beat;
    assign beat_idx = r_idx;
    assign speaker  = (r_click != '0);

endmodule

// File: tb/tb_param_metronome.sv
// Bench for param_metronome: load vector table, hand-written tempo/beat/reset sequences,
// and randomized run segments checked against an arithmetic beat/sweep/click model.
module tb_param_metronome;

    localparam int     CLK_HZ  = 100;
    localparam int     N_LEDS  = 4;
    localparam int     BPM_MIN = 40;
    localparam int     BPM_MAX = 240;
    localparam int     BPM_DEF = 120;
    localparam int     CLICK   = 5;
    localparam int     ACCENT  = 15;
    localparam int     DB      = 8;
    localparam longint THR     = 60 * CLK_HZ;
    localparam int     S       = 2 * (N_LEDS - 1);

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic              bpm_load = 1'b0;
    logic [9:0]        bpm_in = '0;
    logic              key_up_n = 1'b1;
    logic              key_dn_n = 1'b1;
    logic [2:0]        beats_per_bar = 3'd4;
    logic [9:0]        bpm;
    logic [3:0]        bcd100;
    logic [3:0]        bcd10;
    logic [3:0]        bcd1;
    logic [N_LEDS-1:0] led;
    logic              beat;
    logic [2:0]        beat_idx;
    logic              speaker;

    int errors = 0;
    int checks = 0;

    param_metronome #(
        .CLK_HZ(CLK_HZ), .N_LEDS(N_LEDS), .BPM_MIN(BPM_MIN), .BPM_MAX(BPM_MAX),
        .BPM_DEFAULT(BPM_DEF), .CLICK_CYC(CLICK), .ACCENT_CYC(ACCENT), .DB_CYC(DB)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .bpm_load(bpm_load), .bpm_in(bpm_in),
        .key_up_n(key_up_n), .key_dn_n(key_dn_n), .beats_per_bar(beats_per_bar),
        .bpm(bpm), .bcd100(bcd100), .bcd10(bcd10), .bcd1(bcd1), .led(led),
        .beat(beat), .beat_idx(beat_idx), .speaker(speaker)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int v);
        bpm_in   = 10'(v);
        bpm_load = 1'b1;
        step();
        bpm_load = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input int low_cyc);
        key_up_n = ~up;
        key_dn_n = ~dn;
        repeat (low_cyc) step();
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        repeat (20) step();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_led"}, led, 1);
        check({tag, "_speaker"}, speaker, 0);
        check({tag, "_beat_idx"}, beat_idx, 0);
        check({tag, "_beat"}, beat, 0);
    endtask

    // Beats fall where the running total c*bpm crosses a multiple of 60*CLK_HZ;
    // sweep position is the number of S-ths of a beat period elapsed since the last beat.
    task automatic run_segment(input int bpm_v, input int ncyc);
        longint c;
        longint j;
        longint p;
        int     idx;
        int     len;
        int     bpb_v;
        int     sel;
        bit     b;
        c     = 0;
        j     = 0;
        idx   = 0;
        len   = 0;
        bpb_v = int'(beats_per_bar);
        run   = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            step();
            if (n == 0) begin
                b   = 1'b1;
                idx = 0;
            end else begin
                c++;
                b = ((c * bpm_v) / THR) != (((c - 1) * bpm_v) / THR);
                if (b) idx = (idx + 1 >= ((bpb_v == 0) ? 1 : bpb_v)) ? 0 : idx + 1;
            end
            if (b) begin
                j   = 0;
                len = (idx == 0) ? ACCENT : CLICK;
            end else begin
                j++;
            end
            p   = (j * bpm_v * S) / THR;
            sel = (p < N_LEDS) ? int'(p) : S - int'(p);
            check("rand_beat", beat, b);
            check("rand_beat_idx", beat_idx, idx);
            check("rand_led", led, 64'(1) << sel);
            check("rand_speaker", speaker, (j < len) ? 1 : 0);
            if ($urandom_range(0, 39) == 0) begin
                bpb_v         = $urandom_range(0, 7);
                beats_per_bar = 3'(bpb_v);
            end
        end
        run = 1'b0;
        step();
        check_idle("rand_stop");
    endtask

    typedef struct {
        int bpm_in;
        int exp_bpm;
        int d100;
        int d10;
        int d1;
    } load_vec_t;

    load_vec_t vecs[10];

    initial begin
        int p100, p10, p1;
        int beat_at[$];
        int idx_at[$];
        int led_seq[$];
        int exp_leds[6];
        int spk[5];
        int nb;
        bit seen;

        vecs[0] = '{999, 240, 2, 4, 0};
        vecs[1] = '{7, 40, 0, 4, 0};
        vecs[2] = '{123, 123, 1, 2, 3};
        vecs[3] = '{40, 40, 0, 4, 0};
        vecs[4] = '{240, 240, 2, 4, 0};
        vecs[5] = '{39, 40, 0, 4, 0};
        vecs[6] = '{241, 240, 2, 4, 0};
        vecs[7] = '{199, 199, 1, 9, 9};
        vecs[8] = '{1023, 240, 2, 4, 0};
        vecs[9] = '{87, 87, 0, 8, 7};
        exp_leds = '{1, 2, 4, 8, 4, 2};

        // Reset state.
        reset = 1'b0;
        repeat (3) step();
        check("rst_bpm", bpm, BPM_DEF);
        check("rst_bcd100", bcd100, 1);
        check("rst_bcd10", bcd10, 2);
        check("rst_bcd1", bcd1, 0);
        check_idle("rst");
        reset = 1'b1;
        step();

        // Load vectors: clamp, then BCD one cycle later.
        p100 = 1; p10 = 2; p1 = 0;
        for (int i = 0; i < 10; i++) begin
            load(vecs[i].bpm_in);
            check("load_bpm", bpm, vecs[i].exp_bpm);
            check("bcd_latency", {bcd100, bcd10, bcd1}, {4'(p100), 4'(p10), 4'(p1)});
            step();
            check("load_bcd100", bcd100, vecs[i].d100);
            check("load_bcd10", bcd10, vecs[i].d10);
            check("load_bcd1", bcd1, vecs[i].d1);
            p100 = vecs[i].d100; p10 = vecs[i].d10; p1 = vecs[i].d1;
        end

        // Keys: single step per press, saturation, glitch rejection, cancellation.
        load(120);
        press(1'b1, 1'b0, 40);
        check("key_up_once", bpm, 121);
        press(1'b0, 1'b1, 20);
        check("key_dn_once", bpm, 120);
        press(1'b1, 1'b0, 3);
        check("key_glitch", bpm, 120);
        press(1'b1, 1'b1, 20);
        check("key_both_cancel", bpm, 120);
        load(240);
        press(1'b1, 1'b0, 20);
        check("key_up_sat", bpm, 240);
        load(40);
        press(1'b0, 1'b1, 20);
        check("key_dn_sat", bpm, 40);

        // Load held across an up event: the load must win on every cycle.
        load(150);
        key_up_n = 1'b0;
        bpm_in   = 10'd100;
        bpm_load = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            step();
            check("load_beats_key", bpm, 100);
        end
        bpm_load = 1'b0;
        key_up_n = 1'b1;
        repeat (20) step();
        check("key_discarded", bpm, 100);

        // 60 BPM, 4 beats per bar: beat every 100 cycles, accent 15 / click 5, led sweep.
        load(60);
        beats_per_bar = 3'd4;
        spk = '{0, 0, 0, 0, 0};
        run = 1'b1;
        for (int n = 0; n <= 400; n++) begin
            step();
            if (beat) begin
                beat_at.push_back(n);
                idx_at.push_back(int'(beat_idx));
            end
            nb = beat_at.size();
            if (speaker && nb > 0 && nb <= 5) spk[nb-1]++;
            if (n < 100 && (led_seq.size() == 0 || led_seq[$] != int'(led))) led_seq.push_back(int'(led));
            if (n == 100) check("led_realign", led, 1);
        end
        check("beat_count", beat_at.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < beat_at.size()) begin
                check("beat_time", beat_at[k], k * 100);
                check("beat_idx_seq", idx_at[k], k % 4);
            end
        end
        check("click_accent", spk[0], ACCENT);
        for (int k = 1; k < 4; k++) check("click_normal", spk[k], CLICK);
        check("led_seq_len", led_seq.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < led_seq.size()) check("led_seq", led_seq[k], exp_leds[k]);
        end

        // Shrinking the bar below the current index wraps at the next beat.
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            step();
            seen = beat && (beat_idx == 3'd3);
        end
        check("reach_idx3", seen, 1);
        beats_per_bar = 3'd2;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            seen = beat;
        end
        check("wrap_beat_seen", seen, 1);
        check("wrap_idx", beat_idx, 0);
        check("wrap_accent", speaker, 1);
        run = 1'b0;
        step();
        beats_per_bar = 3'd4;

        // Run low mid-sweep at 240 BPM: 35 cycles in is beat 1, sweep position 2.
        load(240);
        run = 1'b1;
        repeat (36) step();
        check("mid_led", led, 4);
        check("mid_idx", beat_idx, 1);
        run = 1'b0;
        step();
        check_idle("runlow");

        // Reset mid-sweep during the accent click.
        run = 1'b1;
        repeat (11) step();
        check("pre_rst_led", led, 4);
        check("pre_rst_speaker", speaker, 1);
        reset = 1'b0;
        step();
        check_idle("midrst");
        check("midrst_bpm", bpm, BPM_DEF);
        run   = 1'b0;
        reset = 1'b1;
        step();

        // Randomized segments against the arithmetic model.
        for (int s = 0; s < 8; s++) begin
            int bv;
            bv = $urandom_range(BPM_MIN, BPM_MAX);
            beats_per_bar = 3'($urandom_range(0, 7));
            load(bv);
            check("seg_bpm", bpm, bv);
            step();
            run_segment(bv, $urandom_range(200, 500));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
